// File: rtl/weight_updater.sv
// weight_updater: single-weight SGD update, weight <= weight - round(grad*eta >> FRAC).
// Two-state FSM: IDLE samples the product on enable_update, CALC writes the new weight.
// Build option: define WEIGHT_SAT_EN to clip out-of-range results and raise the sticky
// sat_flag. Without it, results wrap to DW bits and sat_flag is constant 0.
module weight_updater #(
  parameter int DW   = 16,
  parameter int FRAC = 12
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 enable_update,
  input  logic signed [DW-1:0] grad,
  input  logic signed [DW-1:0] eta,
  input  logic                 load_weight,
  input  logic signed [DW-1:0] init_weight,
  output logic signed [DW-1:0] weight,
  output logic                 busy,
  output logic                 update_done,
  output logic                 sat_flag
);

  localparam int PW = 2 * DW;
  localparam int XW = 2 * DW + 1;
  localparam logic signed [XW-1:0] ROUND = {{(XW-1){1'b0}}, 1'b1} << (FRAC - 1);

  typedef enum logic {IDLE, CALC} state_t;

  state_t               state_q, state_d;
  logic signed [PW-1:0] prod_q, prod_d;
  logic signed [DW-1:0] weight_q, weight_d;
  logic                 done_q, done_d;
  logic signed [XW-1:0] rounded, scaled, diff;
  logic signed [DW-1:0] result;

`ifdef WEIGHT_SAT_EN
  localparam logic signed [XW-1:0] MAXV = {{(DW+2){1'b0}}, {(DW-1){1'b1}}};
  localparam logic signed [XW-1:0] MINV = {{(DW+2){1'b1}}, {(DW-1){1'b0}}};
  logic sat_q, sat_d;
  logic clipped;
`endif

  // Rounded scaling and the wide subtraction, narrowed to DW at the end.
  always_comb begin
    rounded = {prod_q[PW-1], prod_q} + ROUND;
    scaled  = rounded >>> FRAC;
    diff    = {{(DW+1){weight_q[DW-1]}}, weight_q} - scaled;
`ifdef WEIGHT_SAT_EN
    clipped = 1'b0;
    result  = DW'(diff);
    if (diff > MAXV) begin
      result  = {1'b0, {(DW-1){1'b1}}};
      clipped = 1'b1;
    end else if (diff < MINV) begin
      result  = {1'b1, {(DW-1){1'b0}}};
      clipped = 1'b1;
    end
`else
    result = DW'(diff);
`endif
  end

  // Next-state and datapath updates; load_weight overrides everything.
  always_comb begin
    state_d  = state_q;
    prod_d   = prod_q;
    weight_d = weight_q;
    done_d   = 1'b0;
`ifdef WEIGHT_SAT_EN
    sat_d    = sat_q;
`endif
    if (load_weight) begin
      weight_d = init_weight;
      state_d  = IDLE;
`ifdef WEIGHT_SAT_EN
      sat_d    = 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (enable_update) begin
            prod_d  = $signed(grad) * $signed(eta);
            state_d = CALC;
          end
        end
        CALC: begin
          weight_d = result;
          done_d   = 1'b1;
          state_d  = IDLE;
`ifdef WEIGHT_SAT_EN
          sat_d    = sat_q | clipped;
`endif
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // State and datapath registers with asynchronous clear.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      prod_q   <= '0;
      weight_q <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      prod_q   <= prod_d;
      weight_q <= weight_d;
      done_q   <= done_d;
    end
  end

`ifdef WEIGHT_SAT_EN
  // Sticky clip indicator, cleared only by reset or a load.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) sat_q <= 1'b0;
    else       sat_q <= sat_d;
  end
  assign sat_flag = sat_q;
`else
  assign sat_flag = 1'b0;
`endif

  assign weight      = weight_q;
  assign busy        = (state_q == CALC);
  assign update_done = done_q;

endmodule

// File: tb/tb_weight_updater.sv
// Testbench for weight_updater; follows the WEIGHT_SAT_EN setting of the build.
module tb_weight_updater;
  localparam int DW   = 16;
  localparam int FRAC = 12;

  logic                 clk = 1'b0;
  logic                 reset = 1'b1;
  logic                 enable_update = 1'b0;
  logic signed [DW-1:0] grad = '0;
  logic signed [DW-1:0] eta = '0;
  logic                 load_weight = 1'b0;
  logic signed [DW-1:0] init_weight = '0;
  logic signed [DW-1:0] weight;
  logic                 busy, update_done, sat_flag;

  int    n_checks = 0;
  int    n_fail   = 0;
  longint w_m     = 0;
  bit     sat_m   = 0;

  weight_updater #(.DW(DW), .FRAC(FRAC)) dut (
    .clk(clk), .reset(reset), .enable_update(enable_update), .grad(grad), .eta(eta),
    .load_weight(load_weight), .init_weight(init_weight), .weight(weight), .busy(busy),
    .update_done(update_done), .sat_flag(sat_flag)
  );

  always #5 clk = ~clk;

  // Reference: w - floor((g*e + 2^(FRAC-1)) / 2^FRAC), then clip or wrap to DW bits.
  function automatic longint model_next(longint w, longint g, longint e, output bit clip);
    longint prod, scaled, r, lim;
    prod   = g * e;
    scaled = (prod + (longint'(1) << (FRAC - 1))) >>> FRAC;
    r      = w - scaled;
    lim    = longint'(1) << (DW - 1);
    clip   = 1'b0;
`ifdef WEIGHT_SAT_EN
    if (r > lim - 1) begin r = lim - 1; clip = 1'b1; end
    else if (r < -lim) begin r = -lim; clip = 1'b1; end
`else
    r = r & ((longint'(1) << DW) - 1);
    if (r >= lim) r = r - (longint'(1) << DW);
`endif
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_load(input logic signed [DW-1:0] v);
    load_weight = 1'b1;
    init_weight = v;
    tick();
    load_weight = 1'b0;
    w_m = longint'(v);
    sat_m = 1'b0;
    n_checks++;
    if (longint'(weight) !== w_m) begin n_fail++; $display("FAIL load_weight: got %0d want %0d", weight, w_m); end
    n_checks++;
    if (sat_flag !== sat_m) begin n_fail++; $display("FAIL load_sat: got %0b want %0b", sat_flag, sat_m); end
  endtask

  task automatic do_update(input logic signed [DW-1:0] g, input logic signed [DW-1:0] e);
    longint exp_w;
    bit clip;
    enable_update = 1'b1;
    grad = g;
    eta  = e;
    tick();
    enable_update = 1'b0;
    grad = DW'($urandom);
    eta  = DW'($urandom);
    n_checks++;
    if (busy !== 1'b1 || update_done !== 1'b0 || longint'(weight) !== w_m) begin
      n_fail++;
      $display("FAIL upd_calc: busy=%0b done=%0b w=%0d want busy=1 done=0 w=%0d", busy, update_done, weight, w_m);
    end
    exp_w = model_next(w_m, longint'(g), longint'(e), clip);
    tick();
    w_m = exp_w;
    sat_m = sat_m | clip;
    n_checks++;
    if (busy !== 1'b0 || update_done !== 1'b1) begin
      n_fail++;
      $display("FAIL upd_done: busy=%0b done=%0b want busy=0 done=1", busy, update_done);
    end
    n_checks++;
    if (longint'(weight) !== w_m) begin n_fail++; $display("FAIL upd_weight g=%0d e=%0d: got %0d want %0d", g, e, weight, w_m); end
    n_checks++;
    if (sat_flag !== sat_m) begin n_fail++; $display("FAIL upd_sat: got %0b want %0b", sat_flag, sat_m); end
    tick();
    n_checks++;
    if (update_done !== 1'b0 || longint'(weight) !== w_m) begin
      n_fail++;
      $display("FAIL upd_after: done=%0b w=%0d want done=0 w=%0d", update_done, weight, w_m);
    end
  endtask

  task automatic test_reset();
    #12;
    n_checks++;
    if (weight !== '0 || busy !== 1'b0 || update_done !== 1'b0 || sat_flag !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_state: w=%0d busy=%0b done=%0b sat=%0b want all 0", weight, busy, update_done, sat_flag);
    end
    @(posedge clk);
    #1 reset = 1'b0;
    tick();
    n_checks++;
    if (weight !== '0 || busy !== 1'b0) begin n_fail++; $display("FAIL reset_release: w=%0d busy=%0b", weight, busy); end
  endtask

  task automatic test_directed();
    do_load(16'sd4096);
    do_update(16'sd2048, 16'sd1024);
    n_checks++;
    if (weight !== 16'sd3584) begin n_fail++; $display("FAIL basic_3584: got %0d want 3584", weight); end
    do_load(16'sd0);
    do_update(16'sd1, 16'sd2048);
    n_checks++;
    if (weight !== -16'sd1) begin n_fail++; $display("FAIL round_half_up: got %0d want -1", weight); end
    do_update(16'sd1, 16'sd1);
    n_checks++;
    if (weight !== -16'sd1) begin n_fail++; $display("FAIL tiny_update: got %0d want -1", weight); end
  endtask

  task automatic test_saturation();
    do_load(-16'sd32668);
    do_update(16'sd32767, 16'sd32767);
`ifdef WEIGHT_SAT_EN
    n_checks++;
    if (weight !== -16'sd32768 || sat_flag !== 1'b1) begin
      n_fail++; $display("FAIL sat_low: w=%0d sat=%0b want -32768 1", weight, sat_flag);
    end
`else
    n_checks++;
    if (weight !== -16'sd32652 || sat_flag !== 1'b0) begin
      n_fail++; $display("FAIL wrap_low: w=%0d sat=%0b want -32652 0", weight, sat_flag);
    end
`endif
    do_load(16'sd32000);
    do_update(-16'sd32768, 16'sd32767);
    do_update(16'sd0, 16'sd0);
    do_load(16'sd100);
  endtask

  task automatic test_random();
    for (int i = 0; i < 60; i++) begin
      if ($urandom_range(0, 7) == 0) begin
        do_load(DW'($urandom));
      end else if ($urandom_range(0, 1) == 0) begin
        do_update(DW'($urandom), DW'($urandom));
      end else begin
        do_update(DW'($urandom), DW'($urandom_range(0, 8191)) - 16'sd4096);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic signed [DW-1:0] g1, e1, g3, e3;
    longint w1, w2;
    bit c1, c3;
    do_load(16'sd1000);
    g1 = DW'($urandom_range(0, 4000)); e1 = DW'($urandom_range(0, 4000));
    g3 = DW'($urandom_range(0, 4000)); e3 = DW'($urandom_range(0, 4000));
    w1 = model_next(w_m, longint'(g1), longint'(e1), c1);
    w2 = model_next(w1, longint'(g3), longint'(e3), c3);
    enable_update = 1'b1; grad = g1; eta = e1;
    tick();
    grad = 16'sd7777; eta = 16'sd7777;
    n_checks++;
    if (busy !== 1'b1) begin n_fail++; $display("FAIL b2b_busy1: got %0b want 1", busy); end
    tick();
    grad = g3; eta = e3;
    n_checks++;
    if (update_done !== 1'b1 || longint'(weight) !== w1) begin
      n_fail++; $display("FAIL b2b_first: done=%0b w=%0d want 1 %0d", update_done, weight, w1);
    end
    tick();
    enable_update = 1'b0;
    n_checks++;
    if (busy !== 1'b1 || update_done !== 1'b0) begin
      n_fail++; $display("FAIL b2b_busy3: busy=%0b done=%0b want 1 0", busy, update_done);
    end
    tick();
    n_checks++;
    if (update_done !== 1'b1 || longint'(weight) !== w2) begin
      n_fail++; $display("FAIL b2b_second: done=%0b w=%0d want 1 %0d", update_done, weight, w2);
    end
    tick();
    n_checks++;
    if (update_done !== 1'b0 || busy !== 1'b0 || longint'(weight) !== w2) begin
      n_fail++; $display("FAIL b2b_idle: done=%0b busy=%0b w=%0d want 0 0 %0d", update_done, busy, weight, w2);
    end
    w_m = w2;
    sat_m = sat_m | c1 | c3;
  endtask

  task automatic test_load_priority();
    load_weight = 1'b1; enable_update = 1'b1; init_weight = -16'sd1234;
    grad = 16'sd4000; eta = 16'sd4000;
    tick();
    load_weight = 1'b0; enable_update = 1'b0;
    w_m = -1234; sat_m = 1'b0;
    n_checks++;
    if (weight !== -16'sd1234 || busy !== 1'b0 || update_done !== 1'b0) begin
      n_fail++; $display("FAIL load_prio: w=%0d busy=%0b done=%0b want -1234 0 0", weight, busy, update_done);
    end
    tick();
    n_checks++;
    if (update_done !== 1'b0 || weight !== -16'sd1234) begin
      n_fail++; $display("FAIL load_prio_hold: done=%0b w=%0d want 0 -1234", update_done, weight);
    end
    enable_update = 1'b1; grad = 16'sd3000; eta = 16'sd3000;
    tick();
    enable_update = 1'b0;
    load_weight = 1'b1; init_weight = 16'sd555;
    tick();
    load_weight = 1'b0;
    w_m = 555;
    n_checks++;
    if (weight !== 16'sd555 || busy !== 1'b0 || update_done !== 1'b0) begin
      n_fail++; $display("FAIL load_abort: w=%0d busy=%0b done=%0b want 555 0 0", weight, busy, update_done);
    end
    tick();
    n_checks++;
    if (update_done !== 1'b0 || weight !== 16'sd555) begin
      n_fail++; $display("FAIL load_abort_hold: done=%0b w=%0d want 0 555", update_done, weight);
    end
  endtask

  task automatic test_reset_mid_calc();
    do_load(16'sd500);
    enable_update = 1'b1; grad = 16'sd2048; eta = 16'sd2048;
    tick();
    enable_update = 1'b0;
    n_checks++;
    if (busy !== 1'b1) begin n_fail++; $display("FAIL rst_mid_busy: got %0b want 1", busy); end
    #1 reset = 1'b1;
    #1;
    n_checks++;
    if (weight !== '0 || busy !== 1'b0 || update_done !== 1'b0 || sat_flag !== 1'b0) begin
      n_fail++; $display("FAIL rst_mid_async: w=%0d busy=%0b done=%0b sat=%0b want all 0", weight, busy, update_done, sat_flag);
    end
    @(posedge clk);
    #1 reset = 1'b0;
    w_m = 0; sat_m = 1'b0;
    tick();
    n_checks++;
    if (update_done !== 1'b0 || busy !== 1'b0 || weight !== '0) begin
      n_fail++; $display("FAIL rst_mid_release: done=%0b busy=%0b w=%0d want 0 0 0", update_done, busy, weight);
    end
    do_update(16'sd4096, 16'sd300);
  endtask

  initial begin
    test_reset();
    test_directed();
    test_saturation();
    test_back_to_back();
    test_load_priority();
    test_reset_mid_calc();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
